// File: rtl/sha256_ctrl_pkg.sv
// State encoding and block-layout constants shared by the SHA-256 message controller.
// lane_mask builds one big-endian block word with an optional trailing pad byte.
package sha256_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         BLOCK_WORDS = 16;
  localparam int         LEN_WORD_HI = 14;
  localparam int         LEN_WORD_LO = 15;

  // Keep the first nbytes lanes (byte 0 = MSB), drop the pad byte right after them, zero the rest.
  function automatic logic [31:0] lane_mask(input logic [31:0] data,
                                            input logic [2:0]  nbytes,
                                            input logic        pad);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(nbytes))
        w[31-8*b -: 8] = data[31-8*b -: 8];
      else if (pad && (b == int'(nbytes)))
        w[31-8*b -: 8] = PAD_BYTE;
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// Purpose: 16x32 message block register with byte-lane writes, pad-byte insert, length insert and clear.
// Latency: writes visible on blk the cycle after the write strobe.
// Backpressure: none; the controller sequences every write.
module sha256_block_buf
  import sha256_ctrl_pkg::*;
(
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [31:0]  wr_data,
  input  logic [2:0]   wr_nbytes,
  input  logic         wr_pad,
  input  logic         len_en,
  input  logic [63:0]  len_bits,
  output logic [511:0] blk
);

  logic [31:0] mem [BLOCK_WORDS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= lane_mask(wr_data, wr_nbytes, wr_pad);
      if (len_en) begin
        mem[LEN_WORD_HI] <= len_bits[63:32];
        mem[LEN_WORD_LO] <= len_bits[31:0];
      end
    end
  end

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_flat
    assign blk[511-32*i -: 32] = mem[i];
  end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Purpose: sequences a byte-counted word stream into padded 512-bit blocks for one SHA-256 core (SHA256_CTRL_BLKCNT_EN adds blk_count).
// Latency: one core_start per block; digest offered the cycle after the final core_done.
// Backpressure: s_ready only while filling; m_valid/m_digest held until m_ready.
module sha256_msg_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [31:0]  s_data,
  input  logic [2:0]   s_nbytes,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [255:0] m_digest,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] core_in,
  output logic         core_start,
  output logic         core_reset,
  input  logic         core_done,
  input  logic [255:0] core_out
`ifdef SHA256_CTRL_BLKCNT_EN
  ,
  output logic [15:0]  blk_count
`endif
);

  state_t            state_q, state_d;
  logic [3:0]        widx_q;
  logic [LEN_W-1:0]  byte_cnt_q;
  logic              last_seen_q, pad_done_q, final_q;
  logic              buf_clr, wr_en, wr_pad, len_en;
  logic [2:0]        wr_nbytes;
  logic [63:0]       len_bits;

  assign s_ready    = (state_q == ST_FILL);
  assign m_valid    = (state_q == ST_OUT);
  assign core_start = (state_q == ST_INIT) || (state_q == ST_START);
  assign core_reset = (state_q != ST_IDLE) && (state_q != ST_INIT);
  assign len_bits   = {{(61-LEN_W){1'b0}}, byte_cnt_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    buf_clr   = 1'b0;
    wr_en     = 1'b0;
    wr_nbytes = s_nbytes;
    wr_pad    = 1'b0;
    len_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (s_valid) state_d = ST_INIT;
      ST_INIT: begin
        buf_clr = 1'b1;
        state_d = ST_FILL;
      end
      ST_FILL: if (s_valid) begin
        wr_en = 1'b1;
        if (!s_last) begin
          wr_nbytes = 3'd4;
          if (widx_q == 4'd15) state_d = ST_START;
        end else if (s_nbytes < 3'd4) begin
          // Pad lands inside this word; words 14/15 taken means length spills to another block.
          wr_pad  = 1'b1;
          state_d = (widx_q <= 4'd13) ? ST_LEN : ST_START;
        end else begin
          state_d = (widx_q == 4'd15) ? ST_START : ST_PAD;
        end
      end
      ST_PAD: begin
        wr_en     = 1'b1;
        wr_nbytes = 3'd0;
        wr_pad    = 1'b1;
        state_d   = (widx_q <= 4'd13) ? ST_LEN : ST_START;
      end
      ST_LEN: begin
        len_en  = 1'b1;
        state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: if (core_done) begin
        if (final_q) begin
          state_d = ST_OUT;
        end else begin
          buf_clr = 1'b1;
          if (!last_seen_q)     state_d = ST_FILL;
          else if (!pad_done_q) state_d = ST_PAD;
          else                  state_d = ST_LEN;
        end
      end
      ST_OUT: if (m_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      byte_cnt_q  <= '0;
      last_seen_q <= 1'b0;
      pad_done_q  <= 1'b0;
      final_q     <= 1'b0;
      m_digest    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_INIT: begin
          widx_q      <= '0;
          byte_cnt_q  <= '0;
          last_seen_q <= 1'b0;
          pad_done_q  <= 1'b0;
          final_q     <= 1'b0;
        end
        ST_FILL: if (s_valid) begin
          byte_cnt_q  <= byte_cnt_q + LEN_W'(s_nbytes);
          last_seen_q <= s_last;
          pad_done_q  <= s_last && (s_nbytes < 3'd4);
          widx_q      <= widx_q + 4'd1;
        end
        ST_PAD: begin
          pad_done_q <= 1'b1;
          widx_q     <= widx_q + 4'd1;
        end
        ST_LEN: final_q <= 1'b1;
        ST_WAIT: if (core_done) begin
          if (final_q) m_digest <= core_out;
          else         widx_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  sha256_block_buf u_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clr       (buf_clr),
    .wr_en     (wr_en),
    .wr_idx    (widx_q),
    .wr_data   (s_data),
    .wr_nbytes (wr_nbytes),
    .wr_pad    (wr_pad),
    .len_en    (len_en),
    .len_bits  (len_bits),
    .blk       (core_in)
  );

`ifdef SHA256_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      blk_cnt_q <= '0;
    else if (state_q == ST_INIT)
      blk_cnt_q <= '0;
    else if ((state_q == ST_START) && (blk_cnt_q != 16'hFFFF))
      blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: behavioural SHA-256 core beside the DUT, reference digests from a byte-level padding model.
module tb_sha256_msg_ctrl;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  s_data;
  logic [2:0]   s_nbytes;
  logic         s_last, s_valid, s_ready;
  logic [255:0] m_digest;
  logic         m_valid, m_ready;
  logic [511:0] core_in;
  logic         core_start, core_reset, core_done;
  logic [255:0] core_out;
`ifdef SHA256_CTRL_BLKCNT_EN
  logic [15:0]  blk_count;
`endif

  int total = 0;
  int bad = 0;
  int send_tmo = 0;
  logic [7:0] msg_q [$];

  always #5 aclk = ~aclk;

  sha256_msg_ctrl dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_data     (s_data),
    .s_nbytes   (s_nbytes),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_digest   (m_digest),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .core_in    (core_in),
    .core_start (core_start),
    .core_reset (core_reset),
    .core_done  (core_done),
    .core_out   (core_out)
`ifdef SHA256_CTRL_BLKCNT_EN
    ,
    .blk_count  (blk_count)
`endif
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural core: rising start with core_reset=0 loads IV, with core_reset=1 compresses after a random delay.
  // Deliberately not cleared by aresetn, so only the controller's init pulse restores a clean chaining state.
  logic [255:0] core_h;
  logic [511:0] core_blk;
  logic         start_prev;
  int           core_busy = 0;
  int           blk_starts = 0;

  always @(posedge aclk) begin
    start_prev <= core_start;
    if (core_start && !start_prev) begin
      core_done <= 1'b0;
      if (!core_reset) begin
        core_h    <= IV;
        core_busy <= 0;
      end else begin
        core_blk   <= core_in;
        core_busy  <= int'($urandom_range(6, 1));
        blk_starts <= blk_starts + 1;
      end
    end else if (core_busy == 1) begin
      core_h    <= sha_compress(core_h, core_blk);
      core_done <= 1'b1;
      core_busy <= 0;
    end else if (core_busy > 1) begin
      core_busy <= core_busy - 1;
    end
  end
  assign core_out = core_h;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Standard SHA-256 padding on the byte list, then a straight chain of compressions.
  task automatic ref_model(output logic [255:0] dig, output int nblk);
    logic [7:0]   p [$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    logic [255:0] h;
    p = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    nblk = p.size() / 64;
    h = IV;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      h = sha_compress(h, blk);
    end
    dig = h;
  endtask

  task automatic send_msg(input int gap_max, input int max_words);
    int n, nw, nb, waited, gap;
    logic [31:0] w;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nw && i < max_words; i++) begin
      w  = '0;
      nb = (i == nw - 1) ? n - 4 * i : 4;
      for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg_q[4*i + j];
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) @(negedge aclk);
      s_data   = w;
      s_nbytes = 3'(nb);
      s_last   = (i == nw - 1);
      s_valid  = 1'b1;
      waited   = 0;
      while (s_ready !== 1'b1 && waited < 100) begin
        @(negedge aclk);
        waited++;
      end
      if (waited >= 100) send_tmo++;
      @(negedge aclk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic run_msg(input string tag, input bit use_const, input logic [255:0] exp_const,
                         input int hold, input int gap_max);
    logic [255:0] exp_dig;
    int  exp_nb, st0, c;
    bit  stable;
    ref_model(exp_dig, exp_nb);
    st0 = blk_starts;
    send_tmo = 0;
    send_msg(gap_max, 1000);
    c = 0;
    while (m_valid !== 1'b1 && c < 3000) begin
      @(negedge aclk);
      c++;
    end
    chk({tag, ":send_tmo"}, 256'(send_tmo), 256'd0);
    chk({tag, ":out_tmo"}, 256'(c < 3000), 256'd1);
    chk({tag, ":digest"}, m_digest, exp_dig);
    if (use_const) chk({tag, ":known"}, m_digest, exp_const);
    chk({tag, ":blocks"}, 256'(blk_starts - st0), 256'(exp_nb));
    chk({tag, ":s_ready_out"}, 256'(s_ready), 256'd0);
`ifdef SHA256_CTRL_BLKCNT_EN
    chk({tag, ":blk_count"}, 256'(blk_count), 256'(exp_nb));
`endif
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (m_valid !== 1'b1 || m_digest !== exp_dig || s_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, ":hold"}, 256'(stable), 256'd1);
    m_ready = 1'b1;
    @(negedge aclk);
    m_ready = 1'b0;
    chk({tag, ":release"}, {254'd0, m_valid, s_ready}, 256'd0);
  endtask

  int    lens [16];
  string s56;
  int    c;

  initial begin
    aresetn  = 1'b0;
    s_data   = '0;
    s_nbytes = '0;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst:ctrl", {252'd0, s_ready, m_valid, core_start, core_reset}, 256'd0);
    chk("rst:digest", m_digest, 256'd0);
    chk("rst:core_in", core_in[511:256], 256'd0);
    chk("rst:core_in_lo", core_in[255:0], 256'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("idle:ctrl", {253'd0, s_ready, m_valid, core_start}, 256'd0);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b1, D_ABC, 0, 0);

    msg_q.delete();
    run_msg("empty", 1'b1, D_EMPTY, 0, 0);

    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_q.delete();
    for (int i = 0; i < s56.len(); i++) msg_q.push_back(s56[i]);
    run_msg("msg56", 1'b1, D_56, 0, 2);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("b2b_1", 1'b1, D_ABC, 0, 0);
    run_msg("b2b_2", 1'b1, D_ABC, 10, 0);

    // Abort a multi-block message while the core is busy on its first block.
    msg_q.delete();
    for (int i = 0; i < 100; i++) msg_q.push_back(8'($urandom));
    send_msg(0, 16);
    c = 0;
    while (!(core_start === 1'b1 && core_reset === 1'b1) && c < 200) begin
      @(negedge aclk);
      c++;
    end
    chk("rst_wait:start_seen", 256'(c < 200), 256'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("rst_wait:ctrl", {252'd0, s_ready, m_valid, core_start, core_reset}, 256'd0);
    chk("rst_wait:digest", m_digest, 256'd0);
    chk("rst_wait:core_in", core_in[511:256] | core_in[255:0], 256'd0);
    repeat (10) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_after_rst", 1'b1, D_ABC, 0, 0);

    // Lengths around the pad/length split points, then a few random ones.
    lens = '{1, 4, 52, 53, 55, 56, 59, 60, 63, 64, 119, 120, 0, 0, 0, 0};
    for (int k = 12; k < 16; k++) lens[k] = int'($urandom_range(150, 0));
    for (int k = 0; k < 16; k++) begin
      msg_q.delete();
      for (int j = 0; j < lens[k]; j++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", k, lens[k]), 1'b0, 256'd0, (k % 3 == 0) ? 3 : 0, (k % 2 == 1) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
